// File: rtl/ct_spsram_8192x128_ctrl_pkg.sv
// Shared definitions for the 8192x128 single-port SRAM controller:
// array geometry, controller state encoding and the final clear address.
package ct_spsram_8192x128_ctrl_pkg;

  localparam int ADDR_WIDTH    = 13;
  localparam int DATA_WIDTH    = 128;
  localparam int LAST_CLR_ADDR = 8191;
  localparam int CLEAR_CYCLES  = LAST_CLR_ADDR + 1;

  // CLEAR sweeps the array with zeros; RUN serves the two requesters.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ct_f_spsram_8192x128.sv
// Behavioural model of the single-port SRAM macro.
// All control is active-low: CEN selects the cycle, GWEN=0 writes,
// WEN is a per-bit write enable (0 = write that bit). A read registers the
// addressed word on Q; Q holds its value across writes and idle cycles.
module ct_f_spsram_8192x128 #(
  parameter int ADDR_WIDTH = ct_spsram_8192x128_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_8192x128_ctrl_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] a,
  input  logic                  cen,
  input  logic                  gwen,
  input  logic [DATA_WIDTH-1:0] wen,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Synchronous access: bit-masked write or registered read, never both.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!gwen) begin
        mem[a] <= (mem[a] & wen) | (d & ~wen);
      end else begin
        q <= mem[a];
      end
    end
  end

endmodule

// File: rtl/ct_spsram_8192x128_ctrl.sv
// Two-requester controller for a single 8192x128 SRAM macro.
// After reset (or a clr_req pulse) the array is swept to zero, one word per
// cycle; afterwards requesters 0 and 1 share the macro via round-robin.
//
// Handshake: a transfer happens in any cycle where reqN and gntN are both 1.
// gntN is combinational from req0/req1, the priority pointer and the FSM
// state only, so a requester may hold wr/addr/wdata/wmask until it sees its
// grant without creating a loop. A read's data appears exactly one cycle
// after its grant, qualified by rvldN; writes never raise rvld.
module ct_spsram_8192x128_ctrl #(
  parameter int ADDR_WIDTH = ct_spsram_8192x128_ctrl_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_8192x128_ctrl_pkg::DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wmask0,
  input  logic [DATA_WIDTH-1:0] wmask1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvld0,
  output logic                  rvld1,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  clr_req,
  output logic                  init_done,
  output logic                  dbg_state
);

  import ct_spsram_8192x128_ctrl_pkg::*;

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  clr_last;
  logic                  in_run;
  logic                  ptr;

  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  assign in_run    = (state == ST_RUN);
  assign clr_last  = (clr_cnt == ADDR_WIDTH'(LAST_CLR_ADDR));
  assign dbg_state = (state == ST_RUN);

  // Round-robin grant: a lone requester always wins; on contention the
  // pointer decides (ptr=0 favours requester 0). No grants while clearing.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (in_run) begin
      gnt0 = req0 & (~req1 | ~ptr);
      gnt1 = req1 & (~req0 |  ptr);
    end
  end

  // Controller FSM: sweep the array in CLEAR, then serve requests in RUN.
  // clr_req is only honoured in RUN, so a pulse mid-sweep cannot restart it.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= ST_CLEAR;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_last) begin
            state     <= ST_RUN;
            clr_cnt   <= '0;
            init_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state     <= ST_CLEAR;
            init_done <= 1'b0;
          end
        end
      endcase
    end
  end

  // Priority pointer moves to the loser after a grant; read-valid flags
  // follow a granted read by one cycle, matching the macro's Q latency.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ptr   <= 1'b0;
      rvld0 <= 1'b0;
      rvld1 <= 1'b0;
    end else begin
      if (gnt0) begin
        ptr <= 1'b1;
      end else if (gnt1) begin
        ptr <= 1'b0;
      end
      rvld0 <= gnt0 & ~wr0;
      rvld1 <= gnt1 & ~wr1;
    end
  end

  // Macro input mux: clear sweep, granted requester, or idle (CEN high).
  always_comb begin
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (!in_run) begin
      sram_a    = clr_cnt;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_d    = '0;
    end else if (gnt0) begin
      sram_a    = addr0;
      sram_cen  = 1'b0;
      sram_gwen = ~wr0;
      sram_wen  = wr0 ? ~wmask0 : '1;
      sram_d    = wdata0;
    end else if (gnt1) begin
      sram_a    = addr1;
      sram_cen  = 1'b0;
      sram_gwen = ~wr1;
      sram_wen  = wr1 ? ~wmask1 : '1;
      sram_d    = wdata1;
    end
  end

  assign rdata = sram_q;

  ct_f_spsram_8192x128 #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_sram (
    .clk  (forever_cpuclk),
    .a    (sram_a),
    .cen  (sram_cen),
    .gwen (sram_gwen),
    .wen  (sram_wen),
    .d    (sram_d),
    .q    (sram_q)
  );

endmodule

// File: tb/tb_ct_spsram_8192x128_ctrl.sv
// Directed bench for the two-requester SRAM controller. Inputs change on
// the falling clock edge; outputs are sampled 1 ns later.
module tb_ct_spsram_8192x128_ctrl;

  import ct_spsram_8192x128_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req0, req1, wr0, wr1, clr_req;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1, wmask0, wmask1;
  logic                  gnt0, gnt1, rvld0, rvld1, init_done, dbg_state;
  logic [DATA_WIDTH-1:0] rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [DATA_WIDTH-1:0] ZERO   = '0;
  localparam logic [DATA_WIDTH-1:0] ONES   = '1;
  localparam logic [DATA_WIDTH-1:0] PAT_A5 = {16{8'hA5}};
  localparam logic [DATA_WIDTH-1:0] LOW8   = 128'hFF;
  localparam logic [DATA_WIDTH-1:0] MASKED = ~128'hFF;
  localparam logic [DATA_WIDTH-1:0] D0     = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [DATA_WIDTH-1:0] D1     = {4{32'hDEAD_BEEF}};
  localparam logic [DATA_WIDTH-1:0] D3     = {8{16'h3C5A}};

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  ct_spsram_8192x128_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .req0           (req0),
    .req1           (req1),
    .wr0            (wr0),
    .wr1            (wr1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .wmask0         (wmask0),
    .wmask1         (wmask1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rvld0          (rvld0),
    .rvld1          (rvld1),
    .rdata          (rdata),
    .clr_req        (clr_req),
    .init_done      (init_done),
    .dbg_state      (dbg_state)
  );

  // Driver helpers
  task automatic drive_idle();
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0; clr_req = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wmask0 = '0; wmask1 = '0;
  endtask

  // Counts sampled cycles with init_done low, starting at the current
  // sample point; optionally pulses clr_req on sample number pulse_at.
  task automatic measure_clear(input int pulse_at, output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 10000) begin
      n++;
      @(negedge clk);
      clr_req = (n == pulse_at);
      #1;
    end
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    drive_idle();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1}); end
    checks++; if ({rvld0, rvld1} !== 2'b00) begin errors++; $display("FAIL rst_rvld: got %b want 00", {rvld0, rvld1}); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL rst_state: got %b want 0", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    #1;
    measure_clear(0, n);
    checks++; if (n !== CLEAR_CYCLES) begin errors++; $display("FAIL init_clear_len: got %0d want %0d", n, CLEAR_CYCLES); end
    checks++; if (dbg_state !== 1'b1) begin errors++; $display("FAIL init_state_run: got %b want 1", dbg_state); end
  endtask

  // Back-to-back reads of cleared words; first read from requester 1 alone
  task automatic test_clear_reads();
    @(negedge clk); req1 = 1'b1; wr1 = 1'b0; addr1 = 13'd0; #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL rd0_gnt: got %b want 01", {gnt0, gnt1}); end
    @(negedge clk); req1 = 1'b0; req0 = 1'b1; wr0 = 1'b0; addr0 = 13'd4095; #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rd4095_gnt: got %b want 10", {gnt0, gnt1}); end
    checks++; if ({rvld0, rvld1} !== 2'b01 || rdata !== ZERO) begin errors++; $display("FAIL rd0_data: rvld=%b rdata=%h want rvld=01 rdata=0", {rvld0, rvld1}, rdata); end
    @(negedge clk); addr0 = 13'd8191; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd8191_gnt: got %b want 1", gnt0); end
    checks++; if (rvld0 !== 1'b1 || rdata !== ZERO) begin errors++; $display("FAIL rd4095_data: rvld0=%b rdata=%h want 1/0", rvld0, rdata); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== ZERO) begin errors++; $display("FAIL rd8191_data: rvld0=%b rdata=%h want 1/0", rvld0, rdata); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL idle_gnt: got %b want 00", {gnt0, gnt1}); end
    @(negedge clk); #1;
    checks++; if ({rvld0, rvld1} !== 2'b00) begin errors++; $display("FAIL idle_rvld: got %b want 00", {rvld0, rvld1}); end
  endtask

  task automatic test_write_read();
    @(negedge clk); req0 = 1'b1; wr0 = 1'b1; addr0 = 13'h0010; wdata0 = PAT_A5; wmask0 = ONES; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wr10_gnt: got %b want 1", gnt0); end
    @(negedge clk); wr0 = 1'b0; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd10_gnt: got %b want 1", gnt0); end
    checks++; if (rvld0 !== 1'b0) begin errors++; $display("FAIL wr10_no_rvld: got %b want 0", rvld0); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== PAT_A5) begin errors++; $display("FAIL rd10_data: rvld0=%b rdata=%h want 1/%h", rvld0, rdata, PAT_A5); end
  endtask

  task automatic test_mask();
    @(negedge clk); req0 = 1'b1; wr0 = 1'b1; addr0 = 13'h0020; wdata0 = ONES; wmask0 = ONES; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mask_wr1_gnt: got %b want 1", gnt0); end
    @(negedge clk); wdata0 = ZERO; wmask0 = LOW8; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mask_wr2_gnt: got %b want 1", gnt0); end
    @(negedge clk); wr0 = 1'b0; wmask0 = ZERO; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mask_rd_gnt: got %b want 1", gnt0); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== MASKED) begin errors++; $display("FAIL mask_data: rvld0=%b rdata=%h want 1/%h", rvld0, rdata, MASKED); end
  endtask

  // Preload two words, leaving the pointer at 0, then contend for 4 cycles
  task automatic test_round_robin();
    logic exp0, prev0;
    @(negedge clk); req0 = 1'b1; wr0 = 1'b1; addr0 = 13'h0051; wdata0 = D0; wmask0 = ONES; #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rr_pre0_gnt: got %b want 10", {gnt0, gnt1}); end
    @(negedge clk); req0 = 1'b0; req1 = 1'b1; wr1 = 1'b1; addr1 = 13'h0050; wdata1 = D1; wmask1 = ONES; #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++; $display("FAIL rr_pre1_gnt: got %b want 01", {gnt0, gnt1}); end
    @(negedge clk); drive_idle(); #1;
    prev0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1'b1; wr0 = 1'b0; addr0 = 13'h0051;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 13'h0050;
      #1;
      exp0 = (i % 2 == 0);
      checks++; if ({gnt0, gnt1} !== {exp0, ~exp0}) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, {exp0, ~exp0}); end
      if (i > 0) begin
        checks++; if ({rvld0, rvld1} !== {prev0, ~prev0} || rdata !== (prev0 ? D0 : D1)) begin errors++; $display("FAIL rr_data[%0d]: rvld=%b rdata=%h", i, {rvld0, rvld1}, rdata); end
      end
      prev0 = exp0;
    end
    @(negedge clk); drive_idle(); #1;
    checks++; if ({rvld0, rvld1} !== 2'b01 || rdata !== D1) begin errors++; $display("FAIL rr_last_data: rvld=%b rdata=%h want 01/%h", {rvld0, rvld1}, rdata, D1); end
  endtask

  task automatic test_clr_during_read();
    int n;
    @(negedge clk); req0 = 1'b1; wr0 = 1'b1; addr0 = 13'h0030; wdata0 = D3; wmask0 = ONES; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_wr_gnt: got %b want 1", gnt0); end
    @(negedge clk); wr0 = 1'b0; clr_req = 1'b1; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_rd_gnt: got %b want 1", gnt0); end
    @(negedge clk); drive_idle(); req0 = 1'b1; req1 = 1'b1; #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== D3) begin errors++; $display("FAIL clr_rd_data: rvld0=%b rdata=%h want 1/%h", rvld0, rdata, D3); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL clr_init_done: got %b want 0", init_done); end
    checks++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL clr_no_gnt: got %b want 00", {gnt0, gnt1}); end
    req0 = 1'b0; req1 = 1'b0;
    measure_clear(50, n);
    checks++; if (n !== CLEAR_CYCLES) begin errors++; $display("FAIL clr_len: got %0d want %0d", n, CLEAR_CYCLES); end
    @(negedge clk); req0 = 1'b1; wr0 = 1'b0; addr0 = 13'h0030; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL clr_reread_gnt: got %b want 1", gnt0); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== ZERO) begin errors++; $display("FAIL clr_reread_data: rvld0=%b rdata=%h want 1/0", rvld0, rdata); end
  endtask

  // Reset drops a pending rvld, then a second reset lands at clear count 100
  task automatic test_reset_mid_ops();
    int n, bad;
    @(negedge clk); req0 = 1'b1; wr0 = 1'b0; addr0 = 13'h0010; #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mr_gnt: got %b want 1", gnt0); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1) begin errors++; $display("FAIL mr_rvld_pre: got %b want 1", rvld0); end
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; #1;
    checks++; if ({rvld0, rvld1} !== 2'b00) begin errors++; $display("FAIL mr_rvld_drop: got %b want 00", {rvld0, rvld1}); end
    checks++; if ({gnt0, gnt1, init_done, dbg_state} !== 4'b0000) begin errors++; $display("FAIL mr_rst_outs: got %b want 0000", {gnt0, gnt1, init_done, dbg_state}); end
    @(negedge clk); rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0; #1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (init_done !== 1'b0) bad++;
      @(negedge clk); #1;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mc_init_low: got %0d high cycles want 0", bad); end
    rst_n = 1'b0; #1;
    checks++; if (init_done !== 1'b0 || dbg_state !== 1'b0) begin errors++; $display("FAIL mc_rst: init_done=%b state=%b want 0/0", init_done, dbg_state); end
    @(negedge clk); rst_n = 1'b1; #1;
    measure_clear(0, n);
    checks++; if (n !== CLEAR_CYCLES) begin errors++; $display("FAIL mc_clear_len: got %0d want %0d", n, CLEAR_CYCLES); end
    @(negedge clk); req0 = 1'b1; req1 = 1'b1; addr0 = 13'h0020; addr1 = 13'h0021; #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL mc_ptr_reset: got %b want 10", {gnt0, gnt1}); end
    @(negedge clk); drive_idle(); #1;
    checks++; if (rvld0 !== 1'b1 || rdata !== ZERO) begin errors++; $display("FAIL mc_read_data: rvld0=%b rdata=%h want 1/0", rvld0, rdata); end
  endtask

  // Sequencer and final report
  initial begin
    test_reset();
    test_clear_reads();
    test_write_read();
    test_mask();
    test_round_robin();
    test_clr_during_read();
    test_reset_mid_ops();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ct_spsram_8192x128_ctrl.md
CT_SPSRAM_8192X128_CTRL -- requirements
Module: ct_spsram_8192x128_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 13, meaning SRAM word-address width (8192 entries).
REQ-002 SHALL have parameter DATA_WIDTH, default 128, meaning SRAM word width in bits.
REQ-003 SHALL have port forever_cpuclk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port cpurst_b, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports req0/req1, input, 1 each, requester n access request.
REQ-006 SHALL have ports wr0/wr1, input, 1 each: 1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1, input, ADDR_WIDTH each, word address.
REQ-008 SHALL have ports wdata0/wdata1, input, DATA_WIDTH each, write data.
REQ-009 SHALL have ports wmask0/wmask1, input, DATA_WIDTH each: per-bit write enable, active-high.
REQ-010 SHALL have ports gnt0/gnt1, output, 1 each, combinational grant; a transfer occurs when reqn and gntn are both 1.
REQ-011 SHALL have ports rvld0/rvld1, output, 1 each, read data valid for requester n.
REQ-012 SHALL have port rdata, output, DATA_WIDTH, shared read data; meaningful only while rvld0 or rvld1 is 1.
REQ-013 SHALL have port clr_req, input, 1, single-cycle pulse requesting a full-array clear.
REQ-014 SHALL have port init_done, output, 1: 1 = array cleared and controller accepting requests.

Function
REQ-015 SHALL implement states CLEAR and RUN; reset enters CLEAR.
REQ-016 CLEAR SHALL write all-zero data, full mask, to one address per cycle, from 0 up to 2^ADDR_WIDTH-1, using a 13-bit clear counter.
REQ-017 On the cycle the clear counter writes address 8191, the FSM SHALL go to RUN next cycle and reset the counter to 0; the clear takes exactly 8192 cycles.
REQ-018 In CLEAR, gnt0 and gnt1 SHALL be 0 and init_done SHALL be 0.
REQ-019 In RUN, init_done SHALL be 1 and at most one of gnt0/gnt1 SHALL be 1 per cycle.
REQ-020 Arbitration SHALL be round-robin: with only one request pending, that requester is granted; with both pending, the one selected by a 1-bit priority pointer is granted.
REQ-021 After each granted transfer, the pointer SHALL move to the non-granted requester; with no grant, the pointer SHALL hold.
REQ-022 A granted write SHALL drive the SRAM with CEN=0, GWEN=0, WEN = ~wmask, and D = wdata in the grant cycle.
REQ-023 A granted read SHALL drive CEN=0, GWEN=1 in the grant cycle.
REQ-024 For a granted read, rvldn SHALL be 1 exactly one cycle after the grant, with rdata = SRAM Q in that cycle.
REQ-025 Back-to-back reads SHALL be supported at one per cycle, with no bubbles.
REQ-026 A write SHALL produce no rvld.
REQ-027 A read of an address written in the previous cycle SHALL return the new data.
REQ-028 Grant logic SHALL depend only on req0/req1, the pointer and the FSM state, never on wr/addr, so there are no combinational loops through requesters.
REQ-029 In cycles with no access, CEN SHALL be 1.
REQ-030 clr_req seen in RUN SHALL enter CLEAR next cycle.
REQ-031 clr_req in the same cycle as a grant SHALL let that transfer complete, including its rvld in the following cycle.
REQ-032 clr_req during CLEAR SHALL be ignored and SHALL NOT restart the counter.

Reset
REQ-033 When cpurst_b=0, the following SHALL apply asynchronously: FSM=CLEAR, clear counter=0, pointer=0 (requester 0 favoured), rvld0=rvld1=0, init_done=0, gnt0=gnt1=0.
REQ-034 Reset mid-CLEAR or mid-read SHALL abandon the operation, drop any pending rvld, and restart the clear from address 0 after release.
REQ-035 Array contents SHALL NOT be cleared by reset itself, only by the CLEAR state.

Structure
REQ-036 ADDR_WIDTH, DATA_WIDTH, the CLEAR/RUN state encoding and the last clear address (8191) SHALL live in a shared package used by the controller and the bench.
REQ-037 The single sub-module SHALL be the ct_f_spsram_8192x128 macro, instantiated once, fed from a muxed A/CEN/GWEN/WEN/D bundle (clear path or granted requester).

Verification
REQ-038 Reset release -> init_done=0 for 8192 cycles then 1; random reads of addresses 0, 4095, 8191 return 0.
REQ-039 req0 write addr 0x0010 data 0xA5..A5, full mask; next cycle req0 read 0x0010 -> gnt0=1 both cycles, rvld0=1 one cycle after read grant, rdata=0xA5..A5.
REQ-040 req0 and req1 held high for 4 cycles from pointer=0 -> grants 0,1,0,1.
REQ-041 Write 0x0020 full 0xFF..FF, then write 0x0020 data 0, wmask bits[7:0]=1 only, then read -> rdata = 0xFF..FF00.
REQ-042 clr_req in a read grant cycle -> rvld asserted next cycle with the old data, then 8192-cycle clear, then the same address reads 0.
REQ-043 cpurst_b low at clear count 100 -> after release, full 8192-cycle clear again, with init_done low throughout.
